// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU/mul-div operation encodings
// and small decode helpers used by the stage and its testbench-facing logic.
package exe_pkg;

  typedef enum logic [5:0] {
    OpAdd   = 6'd0,
    OpSub   = 6'd1,
    OpAnd   = 6'd2,
    OpOr    = 6'd3,
    OpXor   = 6'd4,
    OpNor   = 6'd5,
    OpSlt   = 6'd6,
    OpSltu  = 6'd7,
    OpSll   = 6'd8,
    OpSrl   = 6'd9,
    OpSra   = 6'd10,
    OpLui   = 6'd11,
    OpPassB = 6'd12,
    OpMult  = 6'd16,
    OpMultu = 6'd17,
    OpDiv   = 6'd18,
    OpDivu  = 6'd19,
    OpMfhi  = 6'd20,
    OpMflo  = 6'd21,
    OpMthi  = 6'd22,
    OpMtlo  = 6'd23
  } alu_op_e;

  // Ops that read or write HI/LO (and therefore must wait for the iterative unit).
  function automatic logic uses_hilo(logic [5:0] op);
    return op inside {OpMult, OpMultu, OpDiv, OpDivu, OpMfhi, OpMflo, OpMthi, OpMtlo};
  endfunction

  // Ops that launch the iterative multiply/divide unit.
  function automatic logic is_muldiv(logic [5:0] op);
    return op inside {OpMult, OpMultu, OpDiv, OpDivu};
  endfunction

endpackage

// File: rtl/exe_muldiv_iter.sv
// Iterative multiply/divide unit, one result bit per cycle.
// Ports: clk, rst_n (async, active-low); start/signed_op/is_div/a/b launch an
// operation when idle; busy is high for exactly WIDTH cycles; done pulses in
// the last busy cycle, during which hi/lo carry the final result.
// Multiply is shift-add on magnitudes, divide is restoring on magnitudes; signs
// are fixed up on the final step.
module exe_muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic             busy_q, div_q, neg_lo_q, neg_hi_q, div0_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic [WIDTH-1:0] hi_n, lo_n, mag_a, mag_b;
  logic [WIDTH:0]   mul_t, rem_sh, diff;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    mag_a  = (signed_op && a[WIDTH-1]) ? -a : a;
    mag_b  = (signed_op && b[WIDTH-1]) ? -b : b;
    mul_t  = lo_q[0] ? ({1'b0, hi_q} + {1'b0, b_q}) : {1'b0, hi_q};
    rem_sh = {hi_q, lo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, b_q};
    if (div_q) begin
      // hi holds the partial remainder, lo shifts dividend bits out and quotient bits in.
      if (!diff[WIDTH]) begin
        hi_n = diff[WIDTH-1:0];
        lo_n = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = rem_sh[WIDTH-1:0];
        lo_n = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      {hi_n, lo_n} = {mul_t, lo_q[WIDTH-1:1]};
    end
    prod = neg_lo_q ? -{hi_n, lo_n} : {hi_n, lo_n};
    if (div_q) begin
      // Divide by zero: remainder magnitude equals |dividend|, so the sign fix
      // restores the dividend; the quotient is forced to all ones.
      lo = div0_q ? '1 : (neg_lo_q ? -lo_n : lo_n);
      hi = neg_hi_q ? -hi_n : hi_n;
    end else begin
      hi = prod[2*WIDTH-1:WIDTH];
      lo = prod[WIDTH-1:0];
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
    end else if (start && !busy_q) begin
      busy_q   <= 1'b1;
      div_q    <= is_div;
      neg_lo_q <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_hi_q <= signed_op && a[WIDTH-1];
      div0_q   <= (b == '0);
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= mag_a;
      b_q      <= mag_b;
    end else if (busy_q) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q + CW'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/exe_multicycle_stage.sv
// Execute stage with single-cycle ALU and a non-blocking iterative mul/div.
// Ports: clk, rst_n (async, active-low); issue slot (in_valid, operands,
// forwarding selects/data, alu_ctrl, shamt, pass-through controls); flush;
// stall_out back to issue; registered out_* results; md_busy.
// HI/LO-touching ops stall only while the iterative unit is busy; other ops
// keep flowing. The mul/div instruction itself retires next cycle with result 0.
module exe_multicycle_stage
  import exe_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     stall_out,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         op_a,
  input  logic [WIDTH-1:0]         op_b,
  input  logic [SEL_W-1:0]         fwd_sel_a,
  input  logic [SEL_W-1:0]         fwd_sel_b,
  input  logic [NUM_FWD*WIDTH-1:0] fwd_data,
  input  logic [5:0]               alu_ctrl,
  input  logic [4:0]               shamt,
  input  logic [4:0]               wr_reg,
  input  logic                     reg_write,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [WIDTH-1:0]         mem_wdata,
  input  logic [WIDTH-1:0]         pc,
  output logic                     out_valid,
  output logic                     out_reg_write,
  output logic                     out_mem_read,
  output logic                     out_mem_write,
  output logic [4:0]               out_wr_reg,
  output logic [WIDTH-1:0]         out_result,
  output logic [WIDTH-1:0]         out_mem_wdata,
  output logic [WIDTH-1:0]         out_pc,
  output logic [5:0]               out_alu_ctrl,
  output logic                     md_busy
);

  logic [WIDTH-1:0] eff_a, eff_b, alu_res, hi_q, lo_q, md_hi, md_lo;
  logic             accept, md_start, md_done;

  // Selects beyond NUM_FWD fall back to the register operand.
  always_comb begin
    eff_a = op_a;
    eff_b = op_b;
    for (int k = 1; k <= NUM_FWD; k++) begin
      if (fwd_sel_a == SEL_W'(k)) eff_a = fwd_data[(k-1)*WIDTH +: WIDTH];
      if (fwd_sel_b == SEL_W'(k)) eff_b = fwd_data[(k-1)*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    alu_res = '0;
    case (alu_op_e'(alu_ctrl))
      OpAdd:   alu_res = eff_a + eff_b;
      OpSub:   alu_res = eff_a - eff_b;
      OpAnd:   alu_res = eff_a & eff_b;
      OpOr:    alu_res = eff_a | eff_b;
      OpXor:   alu_res = eff_a ^ eff_b;
      OpNor:   alu_res = ~(eff_a | eff_b);
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, $signed(eff_a) < $signed(eff_b)};
      OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, eff_a < eff_b};
      OpSll:   alu_res = eff_b << shamt;
      OpSrl:   alu_res = eff_b >> shamt;
      OpSra:   alu_res = $unsigned($signed(eff_b) >>> shamt);
      OpLui:   alu_res = eff_b << 16;
      OpPassB: alu_res = eff_b;
      OpMfhi:  alu_res = hi_q;
      OpMflo:  alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  assign stall_out = in_valid && md_busy && uses_hilo(alu_ctrl);
  assign accept    = in_valid && !flush && !stall_out;
  assign md_start  = accept && is_muldiv(alu_ctrl);

  exe_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (md_start),
    .signed_op(alu_ctrl == OpMult || alu_ctrl == OpDiv),
    .is_div   (alu_ctrl == OpDiv || alu_ctrl == OpDivu),
    .a        (eff_a),
    .b        (eff_b),
    .busy     (md_busy),
    .done     (md_done),
    .hi       (md_hi),
    .lo       (md_lo)
  );

  // MTHI/MTLO stall while busy, so they never collide with a completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (md_done) begin
      hi_q <= md_hi;
      lo_q <= md_lo;
    end else if (accept && alu_ctrl == OpMthi) begin
      hi_q <= eff_a;
    end else if (accept && alu_ctrl == OpMtlo) begin
      lo_q <= eff_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_reg_write <= 1'b0;
      out_mem_read  <= 1'b0;
      out_mem_write <= 1'b0;
      out_wr_reg    <= '0;
      out_result    <= '0;
      out_mem_wdata <= '0;
      out_pc        <= '0;
      out_alu_ctrl  <= '0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_reg_write <= reg_write;
      out_mem_read  <= mem_read;
      out_mem_write <= mem_write;
      out_wr_reg    <= wr_reg;
      out_result    <= alu_res;
      out_mem_wdata <= mem_wdata;
      out_pc        <= pc;
      out_alu_ctrl  <= alu_ctrl;
    end else begin
      out_valid     <= 1'b0;
      out_reg_write <= 1'b0;
      out_mem_read  <= 1'b0;
      out_mem_write <= 1'b0;
      out_wr_reg    <= '0;
      out_result    <= '0;
      out_mem_wdata <= '0;
      out_pc        <= '0;
      out_alu_ctrl  <= '0;
    end
  end

endmodule

// File: tb/tb_exe_multicycle_stage.sv
// Self-checking bench for exe_multicycle_stage: constant vector table, directed
// multi-cycle sequences and random traffic against a behavioural model.
module tb_exe_multicycle_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, flush, reg_write, mem_read, mem_write;
  logic [31:0] op_a, op_b, mem_wdata, pc;
  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic [63:0] fwd_data;
  logic [5:0]  alu_ctrl;
  logic [4:0]  shamt, wr_reg;
  logic        stall_out, out_valid, out_reg_write, out_mem_read, out_mem_write, md_busy;
  logic [4:0]  out_wr_reg;
  logic [31:0] out_result, out_mem_wdata, out_pc;
  logic [5:0]  out_alu_ctrl;

  int checks = 0;
  int failures = 0;

  // Behavioural model state: HI/LO, cycles of busy remaining, pending result.
  int          m_busy = 0;
  logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
  logic        last_stall;

  exe_multicycle_stage #(.WIDTH(32), .NUM_FWD(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall_out(stall_out), .flush(flush),
    .op_a(op_a), .op_b(op_b), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .fwd_data(fwd_data), .alu_ctrl(alu_ctrl), .shamt(shamt), .wr_reg(wr_reg),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .pc(pc), .out_valid(out_valid), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_wr_reg(out_wr_reg),
    .out_result(out_result), .out_mem_wdata(out_mem_wdata), .out_pc(out_pc),
    .out_alu_ctrl(out_alu_ctrl), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic hilo_op(input logic [5:0] op);
    return op >= 6'd16 && op <= 6'd23;
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r);
    if (sel == 2'd1) return fwd_data[31:0];
    if (sel == 2'd2) return fwd_data[63:32];
    return r;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    case (op)
      6'd0:  return a + b;
      6'd1:  return a - b;
      6'd2:  return a & b;
      6'd3:  return a | b;
      6'd4:  return a ^ b;
      6'd5:  return ~(a | b);
      6'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd7:  return (a < b) ? 32'd1 : 32'd0;
      6'd8:  return b << sh;
      6'd9:  return b >> sh;
      6'd10: return $unsigned($signed(b) >>> sh);
      6'd11: return b * 32'h10000;
      6'd12: return b;
      6'd20: return m_hi;
      6'd21: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  task automatic ref_md(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      6'd16: begin sp = longint'(sa) * longint'(sb); hi = sp[63:32]; lo = sp[31:0]; end
      6'd17: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; end
      6'd18: begin
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = 0; end
        else begin lo = sa / sb; hi = sa % sb; end
      end
      default: begin
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endtask

  // One clock of the model with full output comparison.
  task automatic cycle();
    logic [31:0] ea, eb, er;
    logic        st, acc;
    logic [5:0]  op;
    logic [31:0] nhi, nlo;
    #1;
    op  = alu_ctrl;
    ea  = pick(fwd_sel_a, op_a);
    eb  = pick(fwd_sel_b, op_b);
    st  = in_valid && (m_busy > 0) && hilo_op(op);
    last_stall = stall_out;
    chk("stall_out", {31'd0, stall_out}, {31'd0, st});
    acc = in_valid && !flush && !st;
    er  = ref_alu(op, ea, eb, shamt);
    @(posedge clk);
    #1;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin m_hi = m_phi; m_lo = m_plo; end
    end
    if (acc) begin
      if (op >= 6'd16 && op <= 6'd19) begin
        ref_md(op, ea, eb, nhi, nlo);
        m_phi = nhi; m_plo = nlo; m_busy = 32;
      end
      if (op == 6'd22) m_hi = ea;
      if (op == 6'd23) m_lo = ea;
    end
    chk("out_valid", {31'd0, out_valid}, {31'd0, acc});
    chk("out_result", out_result, acc ? er : 32'd0);
    chk("out_alu_ctrl", {26'd0, out_alu_ctrl}, acc ? {26'd0, op} : 32'd0);
    chk("out_ctl", {26'd0, out_reg_write, out_mem_read, out_mem_write, out_wr_reg[2:0]},
        acc ? {26'd0, reg_write, mem_read, mem_write, wr_reg[2:0]} : 32'd0);
    chk("out_wr_reg", {27'd0, out_wr_reg}, acc ? {27'd0, wr_reg} : 32'd0);
    chk("out_mem_wdata", out_mem_wdata, acc ? mem_wdata : 32'd0);
    chk("out_pc", out_pc, acc ? pc : 32'd0);
    chk("md_busy", {31'd0, md_busy}, {31'd0, m_busy > 0});
  endtask

  task automatic drive(input logic v, input logic f, input logic [5:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid = v; flush = f; alu_ctrl = op; op_a = a; op_b = b;
    fwd_sel_a = 0; fwd_sel_b = 0; shamt = 0;
  endtask

  task automatic idle_until_free();
    int n = 0;
    drive(1'b0, 1'b0, 6'd0, 0, 0);
    while (md_busy && n < 100) begin cycle(); n++; end
    chk("wait_free_bound", {31'd0, md_busy}, 32'd0);
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a, b, f0, f1;
    logic [1:0]  sa, sb;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[16];
  logic [5:0] ops[21];

  initial begin
    int n, stalls;
    tbl[0]  = '{6'd0,  32'd5, 32'd3, 32'h10, 32'h20, 2'd1, 2'd0, 5'd0, 32'h13};
    tbl[1]  = '{6'd1,  32'd3, 32'd5, 32'h0, 32'h0, 2'd0, 2'd0, 5'd0, 32'hFFFF_FFFE};
    tbl[2]  = '{6'd2,  32'hF0F0_00FF, 32'h0FF0_0F0F, 0, 0, 2'd0, 2'd0, 5'd0, 32'h00F0_000F};
    tbl[3]  = '{6'd3,  32'hF0, 32'h0F, 0, 0, 2'd0, 2'd0, 5'd0, 32'hFF};
    tbl[4]  = '{6'd4,  32'hFFFF_0000, 32'h0F0F_0F0F, 0, 0, 2'd0, 2'd0, 5'd0, 32'hF0F0_0F0F};
    tbl[5]  = '{6'd5,  32'd0, 32'd0, 0, 0, 2'd0, 2'd0, 5'd0, 32'hFFFF_FFFF};
    tbl[6]  = '{6'd6,  32'hFFFF_FFFF, 32'd1, 0, 0, 2'd0, 2'd0, 5'd0, 32'd1};
    tbl[7]  = '{6'd7,  32'hFFFF_FFFF, 32'd1, 0, 0, 2'd0, 2'd0, 5'd0, 32'd0};
    tbl[8]  = '{6'd8,  32'd0, 32'd1, 0, 0, 2'd0, 2'd0, 5'd31, 32'h8000_0000};
    tbl[9]  = '{6'd9,  32'd0, 32'h8000_0000, 0, 0, 2'd0, 2'd0, 5'd4, 32'h0800_0000};
    tbl[10] = '{6'd10, 32'd0, 32'h8000_0000, 0, 0, 2'd0, 2'd0, 5'd4, 32'hF800_0000};
    tbl[11] = '{6'd11, 32'd0, 32'h1234, 0, 0, 2'd0, 2'd0, 5'd0, 32'h1234_0000};
    tbl[12] = '{6'd12, 32'd9, 32'hDEAD_BEEF, 0, 0, 2'd0, 2'd0, 5'd0, 32'hDEAD_BEEF};
    tbl[13] = '{6'd0,  32'hFFFF_FFFF, 32'd2, 0, 0, 2'd0, 2'd0, 5'd0, 32'd1};
    tbl[14] = '{6'd0,  32'd7, 32'd1, 32'd100, 32'd0, 2'd3, 2'd0, 5'd0, 32'd8};
    tbl[15] = '{6'd0,  32'd1, 32'd9, 32'd0, 32'h20, 2'd0, 2'd2, 5'd0, 32'h21};
    for (int i = 0; i < 13; i++) ops[i] = 6'(i);
    for (int i = 0; i < 8; i++) ops[13+i] = 6'(16 + i);

    drive(1'b0, 1'b0, 6'd0, 0, 0);
    fwd_data = 0; wr_reg = 5'd3; reg_write = 1; mem_read = 0; mem_write = 0;
    mem_wdata = 32'hA5A5; pc = 32'h100;
    #12;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_md_busy", {31'd0, md_busy}, 32'd0);
    chk("reset_out_result", out_result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Constant vector table.
    foreach (tbl[i]) begin
      drive(1'b1, 1'b0, tbl[i].op, tbl[i].a, tbl[i].b);
      fwd_sel_a = tbl[i].sa; fwd_sel_b = tbl[i].sb; shamt = tbl[i].sh;
      fwd_data = {tbl[i].f1, tbl[i].f0};
      cycle();
      chk($sformatf("tbl%0d_result", i), out_result, tbl[i].exp);
      chk($sformatf("tbl%0d_valid", i), {31'd0, out_valid}, 32'd1);
    end

    // MULT -2*3 with ADDs flowing underneath.
    drive(1'b1, 1'b0, 6'd16, 32'hFFFF_FFFE, 32'd3);
    cycle();
    chk("mult_issue_result", out_result, 32'd0);
    n = md_busy ? 1 : 0;
    drive(1'b1, 1'b0, 6'd0, 32'd1, 32'd2);
    while (md_busy && n < 100) begin
      cycle();
      chk("add_no_stall", {31'd0, last_stall}, 32'd0);
      if (md_busy) n++;
    end
    chk("mult_busy_cycles", n, 32);
    drive(1'b1, 1'b0, 6'd20, 0, 0); cycle();
    chk("mult_hi", out_result, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, 6'd21, 0, 0); cycle();
    chk("mult_lo", out_result, 32'hFFFF_FFFA);

    // DIV 7/0 followed by a stalled MFHI.
    drive(1'b1, 1'b0, 6'd18, 32'd7, 32'd0); cycle();
    drive(1'b1, 1'b0, 6'd20, 0, 0);
    stalls = 0; n = 0;
    do begin cycle(); if (last_stall) stalls++; n++; end while (!out_valid && n < 100);
    chk("div0_mfhi_stalls", stalls, 32);
    chk("div0_hi", out_result, 32'd7);
    drive(1'b1, 1'b0, 6'd21, 0, 0); cycle();
    chk("div0_lo", out_result, 32'hFFFF_FFFF);

    // Signed overflow divide.
    drive(1'b1, 1'b0, 6'd18, 32'h8000_0000, 32'hFFFF_FFFF); cycle();
    idle_until_free();
    drive(1'b1, 1'b0, 6'd21, 0, 0); cycle();
    chk("ovf_lo", out_result, 32'h8000_0000);
    drive(1'b1, 1'b0, 6'd20, 0, 0); cycle();
    chk("ovf_hi", out_result, 32'd0);

    // Flush of a MULTU with the unit idle.
    drive(1'b1, 1'b1, 6'd17, 32'd9, 32'd9); cycle();
    chk("flush_bubble", {31'd0, out_valid}, 32'd0);
    chk("flush_no_busy", {31'd0, md_busy}, 32'd0);
    drive(1'b1, 1'b0, 6'd21, 0, 0); cycle();
    chk("flush_lo_kept", out_result, 32'h8000_0000);

    // Reset in the middle of DIVU 100/7.
    drive(1'b1, 1'b0, 6'd19, 32'd100, 32'd7); cycle();
    drive(1'b1, 1'b0, 6'd0, 32'd4, 32'd4);
    repeat (9) cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_ctl", {26'd0, out_reg_write, out_mem_read, out_mem_write, out_alu_ctrl[2:0]},
        32'd0);
    chk("rst_md_busy", {31'd0, md_busy}, 32'd0);
    m_busy = 0; m_hi = 0; m_lo = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 6'd21, 0, 0); cycle();
    chk("rst_mflo", out_result, 32'd0);
    drive(1'b0, 1'b0, 6'd0, 0, 0);
    repeat (40) cycle();
    drive(1'b1, 1'b0, 6'd20, 0, 0); cycle();
    chk("rst_mfhi_late", out_result, 32'd0);
    drive(1'b1, 1'b0, 6'd21, 0, 0); cycle();
    chk("rst_mflo_late", out_result, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 99) < 85);
      flush     = ($urandom_range(0, 99) < 5);
      alu_ctrl  = ops[$urandom_range(0, 20)];
      op_a      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      op_b      = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 15) == 0) begin op_a = 32'h8000_0000; op_b = 32'hFFFF_FFFF; end
      fwd_sel_a = 2'($urandom_range(0, 3));
      fwd_sel_b = 2'($urandom_range(0, 3));
      fwd_data  = {$urandom, $urandom};
      shamt     = 5'($urandom);
      wr_reg    = 5'($urandom);
      reg_write = 1'($urandom);
      mem_read  = 1'($urandom);
      mem_write = 1'($urandom);
      mem_wdata = $urandom;
      pc        = $urandom;
      cycle();
    end
    idle_until_free();
    drive(1'b1, 1'b0, 6'd20, 0, 0); cycle();
    drive(1'b1, 1'b0, 6'd21, 0, 0); cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
